// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file writeback scoreboard.
// Related macro: RF_WB_STARVE_GUARD_EN, which enables the long-latency starvation guard in rf_wb_arb.
package rf_pkg;

    localparam int REG_AW = 5;
    localparam int NREG   = 32;
    localparam int DW     = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic            valid;
        reg_addr_t       addr;
        logic [DW-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arb.sv
// Fixed-priority (ALU first) arbiter for the single register-file write port, with a registered output.
// Defining RF_WB_STARVE_GUARD_EN adds a counter that raises 'starve' after a long-latency result has waited 15 cycles.
module rf_wb_arb
    import rf_pkg::*;
#(
    parameter int DW = rf_pkg::DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_addr,
    input  logic [DW-1:0]     alu_data,
    input  logic              lng_valid,
    input  logic [REG_AW-1:0] lng_addr,
    input  logic [DW-1:0]     lng_data,
    output logic              lng_ready,
    output logic              starve,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DW-1:0]     rf_wdata
);

    logic              win_valid;
    logic [REG_AW-1:0] win_addr;
    logic [DW-1:0]     win_data;
    logic              win_write;

    // The ALU result cannot be back-pressured, so it always wins the port.
    assign lng_ready = ~alu_valid;

    always_comb begin
        win_valid = 1'b0;
        win_addr  = '0;
        win_data  = '0;
        if (alu_valid) begin
            win_valid = 1'b1;
            win_addr  = alu_addr;
            win_data  = alu_data;
        end else if (lng_valid) begin
            win_valid = 1'b1;
            win_addr  = lng_addr;
            win_data  = lng_data;
        end
    end

    // Writes to x0 are suppressed, and address and data only move when a write really happens.
    assign win_write = win_valid & (win_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= win_write;
            if (win_write) begin
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
            end
        end
    end

`ifdef RF_WB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (lng_valid & lng_ready) begin
            starve_cnt <= '0;
        end else if (lng_valid & ~lng_ready & (starve_cnt != 4'hF)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign starve = (starve_cnt == 4'hF);
`else
    assign starve = 1'b0;
`endif

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Tracks pending long-latency destinations, stalls issue on hazards, and sequences the register-file write port.
// The optional starvation guard is enabled with RF_WB_STARVE_GUARD_EN. It stalls ALU-writing issues so the long-latency unit can drain.
module rf_wb_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG     = rf_pkg::NREG,
    parameter int MAX_PEND = 4,
    parameter int DW       = rf_pkg::DW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [REG_AW-1:0]         issue_rs1,
    input  logic [REG_AW-1:0]         issue_rs2,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic                      issue_wr,
    input  logic                      issue_long,
    output logic                      issue_stall,
    input  logic                      alu_wb_valid,
    input  logic [REG_AW-1:0]         alu_wb_addr,
    input  logic [DW-1:0]             alu_wb_data,
    input  logic                      lng_wb_valid,
    input  logic [REG_AW-1:0]         lng_wb_addr,
    input  logic [DW-1:0]             lng_wb_data,
    output logic                      lng_wb_ready,
    output logic                      rf_wen,
    output logic [REG_AW-1:0]         rf_waddr,
    output logic [DW-1:0]             rf_wdata,
    output logic [$clog2(MAX_PEND):0] pend_cnt
);

    localparam int            CW      = $clog2(MAX_PEND) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PEND);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            raw;
    logic            waw;
    logic            full;
    logic            guard;
    logic            starve;
    logic            accept;
    logic            set_en;
    logic            clr_en;
    logic            lng_hs;

    // Hazards are checked against registered state only, so a clear takes effect one cycle later.
    always_comb begin
        raw         = pending[issue_rs1] | pending[issue_rs2];
        waw         = issue_wr & pending[issue_rd];
        full        = issue_wr & issue_long & (pend_cnt == CNT_MAX);
        guard       = starve & issue_wr & ~issue_long;
        issue_stall = issue_valid & (raw | waw | full | guard);
    end

    assign accept = issue_valid & ~issue_stall;
    assign set_en = accept & issue_wr & issue_long & (issue_rd != '0);
    assign lng_hs = lng_wb_valid & lng_wb_ready;
    assign clr_en = lng_hs & pending[lng_wb_addr];

    // Set and clear never target the same register, because a WAW hazard stalls the set.
    always_comb begin
        pending_nxt = pending;
        cnt_nxt     = pend_cnt;
        if (clr_en) begin
            pending_nxt[lng_wb_addr] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
        if (set_en && !clr_en && (pend_cnt != CNT_MAX)) begin
            cnt_nxt = pend_cnt + 1'b1;
        end else if (clr_en && !set_en) begin
            cnt_nxt = pend_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    rf_wb_arb #(
        .DW (DW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_wb_valid),
        .alu_addr  (alu_wb_addr),
        .alu_data  (alu_wb_data),
        .lng_valid (lng_wb_valid),
        .lng_addr  (lng_wb_addr),
        .lng_data  (lng_wb_data),
        .lng_ready (lng_wb_ready),
        .starve    (starve),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Self-checking bench for rf_wb_scoreboard in its default build (RF_WB_STARVE_GUARD_EN undefined).
// The reference model keeps the pending set as a bit array and derives the outstanding count from it.
module tb_rf_wb_scoreboard;

    localparam int MAX_PEND = 4;

    logic        clk = 1'b1;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_wr;
    logic        issue_long;
    logic        issue_stall;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_addr;
    logic [31:0] alu_wb_data;
    logic        lng_wb_valid;
    logic [4:0]  lng_wb_addr;
    logic [31:0] lng_wb_data;
    logic        lng_wb_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  pend_cnt;

    int          vectors = 0;
    int          miscompares = 0;

    bit   [31:0] pend_m;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;

    always #5 clk = ~clk;

    rf_wb_scoreboard #(
        .NREG     (32),
        .MAX_PEND (MAX_PEND),
        .DW       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .issue_wr     (issue_wr),
        .issue_long   (issue_long),
        .issue_stall  (issue_stall),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_addr  (alu_wb_addr),
        .alu_wb_data  (alu_wb_data),
        .lng_wb_valid (lng_wb_valid),
        .lng_wb_addr  (lng_wb_addr),
        .lng_wb_data  (lng_wb_data),
        .lng_wb_ready (lng_wb_ready),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pend_cnt     (pend_cnt)
    );

    function automatic logic model_stall();
        logic hazard;
        hazard = pend_m[issue_rs1] | pend_m[issue_rs2] | (issue_wr & pend_m[issue_rd]) |
                 (issue_wr & issue_long & ($countones(pend_m) == MAX_PEND));
        return issue_valid & hazard;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic wr, input logic lg,
                                 input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld);
        issue_valid  = iv;
        issue_rs1    = rs1;
        issue_rs2    = rs2;
        issue_rd     = rd;
        issue_wr     = wr;
        issue_long   = lg;
        alu_wb_valid = av;
        alu_wb_addr  = aa;
        alu_wb_data  = ad;
        lng_wb_valid = lv;
        lng_wb_addr  = la;
        lng_wb_data  = ld;
    endtask

    // One clock: combinational checks at negedge, model step at posedge, registered checks just after.
    task automatic checkOutput(input string tag, input bit comb_ok);
        logic stall_e;
        logic ready_e;
        @(negedge clk);
        stall_e = model_stall();
        ready_e = ~alu_wb_valid;
        if (comb_ok) begin
            chk(tag, "issue_stall", {31'b0, issue_stall}, {31'b0, stall_e});
            chk(tag, "lng_wb_ready", {31'b0, lng_wb_ready}, {31'b0, ready_e});
        end
        @(posedge clk);
        if (rst) begin
            pend_m    = '0;
            exp_wen   = 1'b0;
            exp_waddr = '0;
            exp_wdata = '0;
        end else begin
            if (lng_wb_valid && !alu_wb_valid) pend_m[lng_wb_addr] = 1'b0;
            if (issue_valid && !stall_e && issue_wr && issue_long && issue_rd != 0) pend_m[issue_rd] = 1'b1;
            exp_wen = 1'b0;
            if (alu_wb_valid) begin
                if (alu_wb_addr != 0) begin
                    exp_wen   = 1'b1;
                    exp_waddr = alu_wb_addr;
                    exp_wdata = alu_wb_data;
                end
            end else if (lng_wb_valid) begin
                if (lng_wb_addr != 0) begin
                    exp_wen   = 1'b1;
                    exp_waddr = lng_wb_addr;
                    exp_wdata = lng_wb_data;
                end
            end
        end
        #1;
        chk(tag, "rf_wen", {31'b0, rf_wen}, {31'b0, exp_wen});
        chk(tag, "rf_waddr", {27'b0, rf_waddr}, {27'b0, exp_waddr});
        chk(tag, "rf_wdata", rf_wdata, exp_wdata);
        chk(tag, "pend_cnt", {29'b0, pend_cnt}, $countones(pend_m));
    endtask

    initial begin
        logic        lv_r;
        logic [4:0]  la_r;
        logic [31:0] ld_r;
        logic        av_r;
        int          idx[$];

        pend_m    = '0;
        exp_wen   = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;

        // Reset with a long result in flight; the result must be dropped.
        rst = 1'b1;
        applyStimulus(1, 5, 5, 5, 1, 1, 0, 0, 0, 1, 5, 32'h55);
        checkOutput("reset0", 0);
        checkOutput("reset1", 1);
        chk("reset", "rf_wen_const", {31'b0, rf_wen}, 32'd0);
        chk("reset", "pend_cnt_const", {29'b0, pend_cnt}, 32'd0);
        rst = 1'b0;

        // RAW hazard on a long destination, released one cycle after the handshake.
        applyStimulus(1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_issue", 1);
        applyStimulus(1, 7, 0, 8, 1, 0, 1, 3, 32'h11, 1, 7, 32'h77);
        checkOutput("raw_wait", 1);
        applyStimulus(1, 7, 0, 8, 1, 0, 0, 0, 0, 1, 7, 32'h77);
        checkOutput("raw_hs", 1);
        chk("raw_hs", "rf_waddr_const", {27'b0, rf_waddr}, 32'd7);
        applyStimulus(1, 7, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_go", 1);

        // ALU and long result collide; the ALU goes first.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 32'hAAAA0000, 1, 9, 32'h1234);
        checkOutput("arb_both", 1);
        chk("arb_both", "rf_wdata_const", rf_wdata, 32'hAAAA0000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h1234);
        checkOutput("arb_lng", 1);
        chk("arb_lng", "rf_waddr_const", {27'b0, rf_waddr}, 32'd9);
        chk("arb_lng", "rf_wdata_const", rf_wdata, 32'h1234);

        // x0 is never pending and never written.
        applyStimulus(1, 0, 0, 0, 1, 1, 1, 0, 32'hDEAD, 0, 0, 0);
        checkOutput("x0", 1);
        chk("x0", "rf_wen_const", {31'b0, rf_wen}, 32'd0);

        // Fill to MAX_PEND; further long issues stall, ALU-only issues go through.
        for (int r = 1; r <= 4; r++) begin
            applyStimulus(1, 0, 0, 5'(r), 1, 1, 0, 0, 0, 0, 0, 0);
            checkOutput("full_fill", 1);
        end
        chk("full_fill", "pend_cnt_const", {29'b0, pend_cnt}, 32'd4);
        applyStimulus(1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("full_stall", 1);
        applyStimulus(1, 10, 0, 11, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("full_alu", 1);

        // Simultaneous clear of x2 and set of x6 keeps the count.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h101);
        checkOutput("clr1", 1);
        applyStimulus(1, 0, 0, 6, 1, 1, 0, 0, 0, 1, 2, 32'h202);
        checkOutput("simul", 1);
        chk("simul", "pend_cnt_const", {29'b0, pend_cnt}, 32'd3);
        applyStimulus(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("probe2", 1);
        applyStimulus(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("probe6", 1);

        // Drain, then a clear of a non-pending register must not underflow.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h303);
        checkOutput("drain3", 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h404);
        checkOutput("drain4", 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h606);
        checkOutput("drain6", 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC0C);
        checkOutput("stray_clr", 1);
        chk("stray_clr", "pend_cnt_const", {29'b0, pend_cnt}, 32'd0);

        // Random traffic with a protocol-compliant long-latency source.
        lv_r = 1'b0;
        la_r = '0;
        ld_r = '0;
        for (int i = 0; i < 500; i++) begin
            if (!lv_r && ($urandom_range(0, 1) == 1)) begin
                idx.delete();
                for (int r = 1; r < 32; r++) if (pend_m[r]) idx.push_back(r);
                if (idx.size() > 0 && $urandom_range(0, 7) != 0)
                    la_r = 5'(idx[$urandom_range(0, idx.size() - 1)]);
                else
                    la_r = 5'($urandom_range(0, 31));
                ld_r = $urandom;
                lv_r = 1'b1;
            end
            av_r = ($urandom_range(0, 2) == 0);
            rst  = (i == 250);
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          av_r, 5'($urandom_range(0, 31)), $urandom, lv_r, la_r, ld_r);
            checkOutput("rand", 1);
            if (lv_r && !av_r) lv_r = 1'b0;
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
